sfp_ctrl: RTL

Sequencer for the special-function (accumulate + ReLU) stage that sits between the psum SRAM and the output SRAM. For one job, it reads every per-kernel-position partial sum of each output location from psum memory. It drives the sfp valid/accumulate/ReLU controls so each location is summed over all kernel positions. It writes one final result per location to output memory, then pulses `done`.

---
 rtl/sfp_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sfp_ctrl.sv
// sfp_ctrl: sequences psum reads through the accumulate/ReLU stage and writes one result per output location.
module sfp_ctrl #(
    parameter int addr_bw = 11,
    parameter int kij_bw  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] cfg_n_out,
    input  logic [kij_bw-1:0]  cfg_n_kij,
    input  logic               cfg_relu,
    output logic               busy,
    output logic               done,
    output logic               pmem_cen,
    output logic [addr_bw-1:0] pmem_addr,
    output logic               sfp_valid_in,
    output logic               sfp_acc_en,
    output logic               sfp_relu_en,
    input  logic               sfp_valid_out,
    output logic               omem_cen,
    output logic               omem_wen,
    output logic [addr_bw-1:0] omem_addr
);
    typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;
    localparam logic [addr_bw-1:0] one_a = 1;
    localparam logic [kij_bw-1:0]  one_k = 1;
    state_t state;
    logic [addr_bw-1:0] n_out, o, base, wr_cnt;
    logic [kij_bw-1:0]  n_kij, kij;
    logic relu, s1_first, s1_job_first, s2_commit, wr;
    // The sum of a location leaves the sfp on the first beat of the next group.
    assign wr          = sfp_valid_out & s2_commit;
    assign omem_cen    = ~wr;
    assign omem_wen    = ~wr;
    assign omem_addr   = wr_cnt;
    assign sfp_relu_en = relu;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            pmem_cen     <= 1'b1;
            pmem_addr    <= '0;
            sfp_valid_in <= 1'b0;
            sfp_acc_en   <= 1'b0;
            s1_first     <= 1'b0;
            s1_job_first <= 1'b0;
            s2_commit    <= 1'b0;
            n_out        <= '0;
            n_kij        <= '0;
            relu         <= 1'b0;
            o            <= '0;
            kij          <= '0;
            base         <= '0;
            wr_cnt       <= '0;
        end else begin
            sfp_valid_in <= 1'b0;
            sfp_acc_en   <= 1'b0;
            s1_first     <= 1'b0;
            s1_job_first <= 1'b0;
            s2_commit    <= sfp_valid_in & s1_first & ~s1_job_first;
            done         <= 1'b0;
            if (wr) wr_cnt <= wr_cnt + one_a;
            case (state)
                IDLE: if (start) begin
                    n_out  <= cfg_n_out;
                    n_kij  <= cfg_n_kij;
                    relu   <= cfg_relu;
                    o      <= '0;
                    kij    <= '0;
                    base   <= '0;
                    wr_cnt <= '0;
                    busy   <= 1'b1;
                    if (cfg_n_out == '0 || cfg_n_kij == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= RUN;
                        pmem_cen  <= 1'b0;
                        pmem_addr <= '0;
                    end
                end
                RUN: begin
                    sfp_valid_in <= 1'b1;
                    sfp_acc_en   <= kij != '0;
                    s1_first     <= kij == '0;
                    s1_job_first <= o == '0 && kij == '0;
                    if (kij == n_kij - one_k) begin
                        kij  <= '0;
                        base <= '0;
                        if (o == n_out - one_a) begin
                            state     <= FLUSH;
                            pmem_cen  <= 1'b1;
                            pmem_addr <= '0;
                        end else begin
                            o         <= o + one_a;
                            pmem_addr <= o + one_a;
                        end
                    end else begin
                        kij       <= kij + one_k;
                        base      <= base + n_out;
                        pmem_addr <= base + n_out + o;
                    end
                end
                FLUSH: begin
                    sfp_valid_in <= 1'b1;
                    s1_first     <= 1'b1;
                    state        <= DRAIN;
                end
                DRAIN: if (wr && wr_cnt == n_out - one_a) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    relu  <= 1'b0;
                    n_out <= '0;
                    n_kij <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
